// File: rtl/mysystem_hex_pkg.sv
// Shared definitions for the six-digit hex display writer: FSM encoding,
// seven-segment lookup table and byte-lane packing helper.
package mysystem_hex_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WR_LO = 3'd1,
    ST_WR_HI = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERR   = 3'd4
  } state_e;

  // Active-low segments, bit0=a .. bit6=g; entry n is the code for digit n.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  function automatic logic [7:0] seg_lane(input logic [6:0] seg);
    return {1'b0, seg};
  endfunction

endpackage

// File: rtl/mysystem_hex_writer_if.sv
// Avalon-MM write-only master bus between the hex writer and the display slaves.
interface mysystem_hex_writer_if #(
  parameter int ADDR_W = 2
);
  logic [ADDR_W-1:0] avm_address;
  logic              avm_chipselect;
  logic              avm_write_n;
  logic [31:0]       avm_writedata;
  logic              avm_waitrequest;

  modport master (
    output avm_address, avm_chipselect, avm_write_n, avm_writedata,
    input  avm_waitrequest
  );

  modport slave (
    input  avm_address, avm_chipselect, avm_write_n, avm_writedata,
    output avm_waitrequest
  );
endinterface

// File: rtl/mysystem_hex_seg7_enc.sv
// Combinational hex digit to active-low seven-segment code, with blanking.
module mysystem_hex_seg7_enc
  import mysystem_hex_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       blank,
  output logic [6:0] seg
);
  assign seg = blank ? SEG_BLANK : SEG_TABLE[digit];
endmodule

// File: rtl/mysystem_hex_writer.sv
// Writes a latched six-digit hex value to two Avalon-MM display registers.
// state | meaning: IDLE wait start | WR_LO HEX3..0 write | WR_HI HEX5..4 write | DONE ok pulse | ERR timeout pulse
module mysystem_hex_writer
  import mysystem_hex_pkg::*;
#(
  parameter int ADDR_W     = 2,
  parameter int HEX30_ADDR = 0,
  parameter int HEX54_ADDR = 1,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [23:0]           value,
  input  logic [5:0]            blank_mask,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  mysystem_hex_writer_if.master avm
);
  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  state_e           state_q, state_d;
  logic [23:0]      value_q, value_d;
  logic [5:0]       mask_q, mask_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [5:0][6:0]  seg;
  logic             timeout_hit;

  for (genvar i = 0; i < 6; i++) begin : g_enc
    mysystem_hex_seg7_enc u_enc (
      .digit (value_q[4*i +: 4]),
      .blank (mask_q[i]),
      .seg   (seg[i])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      value_q    <= '0;
      mask_q     <= '0;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      value_q    <= value_d;
      mask_q     <= mask_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // Abort when this stalled cycle brings the wait count up to TIMEOUT.
  assign timeout_hit = avm.avm_waitrequest && (wait_cnt_q == CNT_W'(TIMEOUT - 1));

  always_comb begin
    state_d    = state_q;
    value_d    = value_q;
    mask_d     = mask_q;
    wait_cnt_d = wait_cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          value_d    = value;
          mask_d     = blank_mask;
          wait_cnt_d = '0;
          state_d    = ST_WR_LO;
        end
      end
      ST_WR_LO, ST_WR_HI: begin
        if (avm.avm_waitrequest) begin
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
          if (timeout_hit) state_d = ST_ERR;
        end else begin
          wait_cnt_d = '0;
          state_d    = (state_q == ST_WR_LO) ? ST_WR_HI : ST_DONE;
        end
      end
      ST_DONE, ST_ERR: state_d = ST_IDLE;
      default:         state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy               = 1'b0;
    done               = 1'b0;
    error              = 1'b0;
    avm.avm_chipselect = 1'b0;
    avm.avm_write_n    = 1'b1;
    avm.avm_address    = '0;
    avm.avm_writedata  = '0;
    unique case (state_q)
      ST_WR_LO: begin
        busy               = 1'b1;
        avm.avm_chipselect = 1'b1;
        avm.avm_write_n    = 1'b0;
        avm.avm_address    = ADDR_W'(HEX30_ADDR);
        avm.avm_writedata  = {seg_lane(seg[3]), seg_lane(seg[2]),
                              seg_lane(seg[1]), seg_lane(seg[0])};
      end
      ST_WR_HI: begin
        busy               = 1'b1;
        avm.avm_chipselect = 1'b1;
        avm.avm_write_n    = 1'b0;
        avm.avm_address    = ADDR_W'(HEX54_ADDR);
        avm.avm_writedata  = {16'h0000, seg_lane(seg[5]), seg_lane(seg[4])};
      end
      ST_DONE: done  = 1'b1;
      ST_ERR:  error = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mysystem_hex_writer.sv
// Scoreboard bench for the hex writer: stimulus queues expected writes and
// status pulses, a negedge monitor (which also plays the stalling slave) checks them.
module tb_mysystem_hex_writer;
  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [23:0] value;
  logic [5:0]  blank_mask;
  logic        busy, done, error;

  mysystem_hex_writer_if #(.ADDR_W(2)) avm_if ();

  mysystem_hex_writer #(
    .ADDR_W(2), .HEX30_ADDR(0), .HEX54_ADDR(1), .TIMEOUT(255)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .value      (value),
    .blank_mask (blank_mask),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .avm        (avm_if)
  );

  always #5 clk = ~clk;

  typedef struct { logic [1:0] addr; logic [31:0] data; } wr_t;
  typedef struct { int kind; int at; } st_t;

  wr_t wq[$];
  st_t sq[$];
  int  total = 0, bad = 0, cyc = 0;
  int  stall_lo = 0, stall_hi = 0, cs_cycles = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Slave stall model plus scoreboard checker.
  always @(negedge clk) begin
    logic stall;
    st_t  st;
    stall = 1'b0;
    if (avm_if.avm_chipselect) begin
      cs_cycles++;
      stall = (avm_if.avm_address == 2'd0) ? (stall_lo > 0) : (stall_hi > 0);
      if (stall) begin
        if (avm_if.avm_address == 2'd0) stall_lo--;
        else stall_hi--;
      end
      chk("write_n", {31'd0, avm_if.avm_write_n}, 32'd0);
      if (wq.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_write: got addr %0d data %h want none", avm_if.avm_address, avm_if.avm_writedata);
      end else begin
        chk("address", {30'd0, avm_if.avm_address}, {30'd0, wq[0].addr});
        chk("writedata", avm_if.avm_writedata, wq[0].data);
        if (!stall) void'(wq.pop_front());
      end
    end
    avm_if.avm_waitrequest = stall;
    if (done || error) begin
      chk("busy_at_status", {31'd0, busy}, 32'd0);
      if (sq.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_status: got done=%0b error=%0b want none", done, error);
      end else begin
        st = sq.pop_front();
        chk("status_kind", {30'd0, error, done}, st.kind);
        chk("status_cycle", cyc, st.at);
      end
    end
  end

  // kind: 0 = no status expected, 1 = done, 2 = error (low write never completes)
  task automatic issue(input logic [23:0] v, input logic [5:0] m, input logic [31:0] lo,
                       input logic [31:0] hi, input int kind, input int lat);
    @(negedge clk);
    value = v; blank_mask = m; start = 1'b1;
    wq.push_back('{addr: 2'd0, data: lo});
    if (kind != 2) wq.push_back('{addr: 2'd1, data: hi});
    if (kind != 0) sq.push_back('{kind: kind, at: cyc + lat});
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", {31'd0, busy}, 32'd1);
  endtask

  task automatic wait_quiet(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (sq.size() == 0) break;
      @(negedge clk);
    end
    if (sq.size() != 0) begin
      total++; bad++;
      $display("FAIL status_timeout: got no pulse want kind %0d at %0d", sq[0].kind, sq[0].at);
      sq.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_done"}, {31'd0, done}, 32'd0);
    chk({tag, "_error"}, {31'd0, error}, 32'd0);
    chk({tag, "_cs"}, {31'd0, avm_if.avm_chipselect}, 32'd0);
    chk({tag, "_write_n"}, {31'd0, avm_if.avm_write_n}, 32'd1);
    chk({tag, "_addr"}, {30'd0, avm_if.avm_address}, 32'd0);
    chk({tag, "_data"}, avm_if.avm_writedata, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, base;
    reset = 1'b1; start = 1'b0; value = '0; blank_mask = '0;
    repeat (3) @(negedge clk);
    check_idle("reset");
    reset = 1'b0;

    // plain write pair, minimum latency
    issue(24'h012345, 6'b000000, 32'h24301912, 32'h00004079, 1, 3);
    wait_quiet(50);

    // upper two digits blanked
    issue(24'hABCDEF, 6'b110000, 32'h4621060E, 32'h00007F7F, 1, 3);
    wait_quiet(50);

    // five stall cycles on the low write
    stall_lo = 5;
    issue(24'h987654, 6'b000101, 32'h787F127F, 32'h00001000, 1, 8);
    wait_quiet(50);

    // stall on the high write
    stall_hi = 2;
    issue(24'hFEDCBA, 6'b001010, 32'h7F467F08, 32'h00000E06, 1, 5);
    wait_quiet(50);

    // stuck waitrequest: timeout abort, high write skipped
    stall_lo = 1000;
    base = cs_cycles;
    issue(24'h111111, 6'b000000, 32'h79797979, 32'h0, 2, 256);
    wait_quiet(600);
    chk("timeout_cs_cycles", cs_cycles - base, 32'd255);
    chk("timeout_pending_low", wq.size(), 32'd1);
    wq.delete();
    stall_lo = 0;
    check_idle("after_err");

    // restart while busy, input change mid-flight, start during DONE
    stall_lo = 2;
    issue(24'hC0FFEE, 6'b000000, 32'h0E0E0606, 32'h00004640, 1, 5);
    c0 = cyc;
    value = 24'h000000; blank_mask = 6'h3F; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 20 && cyc < c0 + 4; i++) @(negedge clk);
    chk("done_cycle_start", {31'd0, done}, 32'd1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    chk("restart_queue_empty", wq.size() + sq.size(), 32'd0);

    // reset during the high write: drop it, no done
    stall_hi = 3;
    issue(24'h000000, 6'b000000, 32'h40404040, 32'h00004040, 0, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_idle("mid_reset");
    chk("reset_pending_high", wq.size(), 32'd1);
    wq.delete();
    reset = 1'b0;
    stall_hi = 0;
    repeat (5) @(negedge clk);

    // recovery after reset, all digits blanked
    issue(24'h5A5A5A, 6'b111111, 32'h7F7F7F7F, 32'h00007F7F, 1, 3);
    wait_quiet(50);

    chk("final_write_queue", wq.size(), 32'd0);
    chk("final_status_queue", sq.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
